// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM->WB pipeline register of the 5-stage MIPS core.
// Extracts and extends the loaded byte/halfword/word from the raw DM word,
// selects the write-back source, flags misaligned loads and registers the
// GRF write-back controls. All W_* outputs are registers.
// Ports:
//   clk, Reset (sync, active-high), Stall (hold), Flush (bubble)
//   M_Valid, M_PC, M_LoadOp, M_WDSel, M_Address, M_DMData, M_RegWE, M_WriteReg
//   W_RegWE, W_WriteReg, W_WriteData, W_PC, W_Valid, W_AdEL, W_Retired
module mem_wb_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             Flush,
  input  logic             M_Valid,
  input  logic [31:0]      M_PC,
  input  logic [2:0]       M_LoadOp,
  input  logic [1:0]       M_WDSel,
  input  logic [31:0]      M_Address,
  input  logic [31:0]      M_DMData,
  input  logic             M_RegWE,
  input  logic [4:0]       M_WriteReg,
  output logic             W_RegWE,
  output logic [4:0]       W_WriteReg,
  output logic [31:0]      W_WriteData,
  output logic [31:0]      W_PC,
  output logic             W_Valid,
  output logic             W_AdEL,
  output logic [CNT_W-1:0] W_Retired
);

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] OP_LBU = 3'd1;
  localparam logic [2:0] OP_LB  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LH  = 3'd4;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC8 = 2'd2;

  logic [1:0]      byte_off;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data;
  logic [XLEN-1:0] sel_data;
  logic            misalign;
  logic            wr_zero;
  logic            next_regwe;
  logic [XLEN-1:0] next_wdata;

  assign byte_off = M_Address[1:0];

  // Byte and halfword lanes of the DM word chosen by the low address bits
  always_comb begin
    ld_byte = M_DMData[7:0];
    case (byte_off)
      2'd0:    ld_byte = M_DMData[7:0];
      2'd1:    ld_byte = M_DMData[15:8];
      2'd2:    ld_byte = M_DMData[23:16];
      default: ld_byte = M_DMData[31:24];
    endcase
    ld_half = byte_off[1] ? M_DMData[31:16] : M_DMData[15:0];
  end

  // Extension per load opcode; reserved opcodes behave as LW
  always_comb begin
    ld_data  = M_DMData;
    misalign = (byte_off != 2'd0);
    case (M_LoadOp)
      OP_LBU: begin
        ld_data  = {24'd0, ld_byte};
        misalign = 1'b0;
      end
      OP_LB: begin
        ld_data  = {{24{ld_byte[7]}}, ld_byte};
        misalign = 1'b0;
      end
      OP_LHU: begin
        ld_data  = {16'd0, ld_half};
        misalign = byte_off[0];
      end
      OP_LH: begin
        ld_data  = {{16{ld_half[15]}}, ld_half};
        misalign = byte_off[0];
      end
      default: begin
        ld_data  = M_DMData;
        misalign = (byte_off != 2'd0);
      end
    endcase
    // Alignment only matters when the load result is actually written back
    if (M_WDSel != WD_MEM) misalign = 1'b0;
  end

  // Write-back source select, then $0 and misalign suppression
  always_comb begin
    sel_data = '0;
    case (M_WDSel)
      WD_ALU:  sel_data = M_Address;
      WD_MEM:  sel_data = ld_data;
      WD_PC8:  sel_data = M_PC + XLEN'(8);
      default: sel_data = '0;
    endcase
    wr_zero    = (M_WriteReg == 5'd0);
    next_regwe = M_RegWE && !misalign && !wr_zero;
    next_wdata = (misalign || wr_zero) ? '0 : sel_data;
  end

  // WB register bank: Reset > Flush > Stall > bubble/normal capture
  always_ff @(posedge clk) begin
    if (Reset) begin
      W_RegWE     <= 1'b0;
      W_WriteReg  <= 5'd0;
      W_WriteData <= '0;
      W_PC        <= RESET_PC;
      W_Valid     <= 1'b0;
      W_AdEL      <= 1'b0;
      W_Retired   <= '0;
    end else if (Flush || (!Stall && !M_Valid)) begin
      W_RegWE     <= 1'b0;
      W_WriteReg  <= 5'd0;
      W_WriteData <= '0;
      W_PC        <= RESET_PC;
      W_Valid     <= 1'b0;
      W_AdEL      <= 1'b0;
    end else if (!Stall) begin
      W_RegWE     <= next_regwe;
      W_WriteReg  <= M_WriteReg;
      W_WriteData <= next_wdata;
      W_PC        <= M_PC;
      W_Valid     <= 1'b1;
      W_AdEL      <= misalign;
      W_Retired   <= W_Retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with a 4-bit retire counter so the wrap
// is reachable in a short run.
module tb_mem_wb_stage;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          Reset, Stall, Flush, M_Valid, M_RegWE;
  logic [31:0]   M_PC, M_Address, M_DMData;
  logic [2:0]    M_LoadOp;
  logic [1:0]    M_WDSel;
  logic [4:0]    M_WriteReg;
  logic          W_RegWE, W_Valid, W_AdEL;
  logic [4:0]    W_WriteReg;
  logic [31:0]   W_WriteData, W_PC;
  logic [CW-1:0] W_Retired;

  int checks = 0;
  int errors = 0;

  mem_wb_stage #(.RESET_PC(32'h0000_3000), .CNT_W(CW)) dut (
    .clk(clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
    .M_Valid(M_Valid), .M_PC(M_PC), .M_LoadOp(M_LoadOp), .M_WDSel(M_WDSel),
    .M_Address(M_Address), .M_DMData(M_DMData), .M_RegWE(M_RegWE),
    .M_WriteReg(M_WriteReg),
    .W_RegWE(W_RegWE), .W_WriteReg(W_WriteReg), .W_WriteData(W_WriteData),
    .W_PC(W_PC), .W_Valid(W_Valid), .W_AdEL(W_AdEL), .W_Retired(W_Retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [2:0] op,
                       input logic [1:0] wd, input logic [31:0] addr,
                       input logic [31:0] data, input logic we, input logic [4:0] wr);
    M_Valid = v; M_PC = pc; M_LoadOp = op; M_WDSel = wd;
    M_Address = addr; M_DMData = data; M_RegWE = we; M_WriteReg = wr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    Reset = 1'b1; Stall = 1'b0; Flush = 1'b0;
    drive(1'b1, 32'h0000_1234, 3'd0, 2'd0, 32'h1111_1111, 32'h2222_2222, 1'b1, 5'd7);
    tick();
    tick();
    // 1: reset state
    chk("rst_regwe",  32'(W_RegWE), 32'd0);
    chk("rst_wr",     32'(W_WriteReg), 32'd0);
    chk("rst_wdata",  W_WriteData, 32'd0);
    chk("rst_pc",     W_PC, 32'h0000_3000);
    chk("rst_valid",  32'(W_Valid), 32'd0);
    chk("rst_adel",   32'(W_AdEL), 32'd0);
    chk("rst_ret",    32'(W_Retired), 32'd0);
    Reset = 1'b0;

    // 2: LB / LBU byte lanes
    drive(1'b1, 32'h0000_3000, 3'd2, 2'd1, 32'h0000_0101, 32'h80FF_7F01, 1'b1, 5'd8);
    tick();
    chk("lb_b1", W_WriteData, 32'h0000_007F);
    chk("lb_b1_we", 32'(W_RegWE), 32'd1);
    chk("lb_b1_valid", 32'(W_Valid), 32'd1);
    chk("lb_b1_pc", W_PC, 32'h0000_3000);
    chk("lb_b1_ret", 32'(W_Retired), 32'd1);
    M_Address = 32'h0000_0102;
    tick();
    chk("lb_b2", W_WriteData, 32'hFFFF_FFFF);
    M_Address = 32'h0000_0103;
    tick();
    chk("lb_b3", W_WriteData, 32'hFFFF_FF80);
    M_LoadOp = 3'd1;
    tick();
    chk("lbu_b3", W_WriteData, 32'h0000_0080);
    chk("lbu_ret", 32'(W_Retired), 32'd4);

    // 3: halfword loads and misalignment
    drive(1'b1, 32'h0000_3004, 3'd4, 2'd1, 32'h0000_0202, 32'h8001_1234, 1'b1, 5'd8);
    tick();
    chk("lh_h1", W_WriteData, 32'hFFFF_8001);
    M_LoadOp = 3'd3;
    tick();
    chk("lhu_h1", W_WriteData, 32'h0000_8001);
    M_LoadOp = 3'd4; M_Address = 32'h0000_0201;
    tick();
    chk("lh_mis_adel", 32'(W_AdEL), 32'd1);
    chk("lh_mis_we", 32'(W_RegWE), 32'd0);
    chk("lh_mis_wd", W_WriteData, 32'd0);
    chk("lh_mis_wr", 32'(W_WriteReg), 32'd8);
    chk("lh_mis_ret", 32'(W_Retired), 32'd7);

    // 4: PC+8 and $0 rule
    drive(1'b1, 32'h0000_300C, 3'd0, 2'd2, 32'h0000_0001, 32'h0, 1'b1, 5'd31);
    tick();
    chk("pc8_wd", W_WriteData, 32'h0000_3014);
    chk("pc8_we", 32'(W_RegWE), 32'd1);
    chk("pc8_adel", 32'(W_AdEL), 32'd0);
    M_WriteReg = 5'd0;
    tick();
    chk("r0_we", 32'(W_RegWE), 32'd0);
    chk("r0_wd", W_WriteData, 32'd0);
    drive(1'b1, 32'h0000_3010, 3'd0, 2'd0, 32'h1234_5678, 32'h0, 1'b1, 5'd5);
    tick();
    chk("alu_wd", W_WriteData, 32'h1234_5678);
    M_WDSel = 2'd3;
    tick();
    chk("rsv_wd", W_WriteData, 32'd0);
    chk("rsv_ret", 32'(W_Retired), 32'd11);

    // 5: stall / flush interaction
    drive(1'b1, 32'h0000_3020, 3'd0, 2'd1, 32'h0000_0400, 32'hDEAD_BEEF, 1'b1, 5'd4);
    tick();
    chk("lw_wd", W_WriteData, 32'hDEAD_BEEF);
    chk("lw_ret", 32'(W_Retired), 32'd12);
    drive(1'b1, 32'h0000_3024, 3'd0, 2'd1, 32'h0000_0404, 32'h0000_0000, 1'b1, 5'd9);
    Stall = 1'b1;
    tick();
    chk("stall_wd", W_WriteData, 32'hDEAD_BEEF);
    chk("stall_pc", W_PC, 32'h0000_3020);
    chk("stall_wr", 32'(W_WriteReg), 32'd4);
    chk("stall_ret", 32'(W_Retired), 32'd12);
    Flush = 1'b1;
    tick();
    chk("sf_valid", 32'(W_Valid), 32'd0);
    chk("sf_pc", W_PC, 32'h0000_3000);
    chk("sf_we", 32'(W_RegWE), 32'd0);
    chk("sf_wr", 32'(W_WriteReg), 32'd0);
    chk("sf_ret", 32'(W_Retired), 32'd12);
    Flush = 1'b0;
    tick();
    chk("stall_bub_valid", 32'(W_Valid), 32'd0);
    chk("stall_bub_ret", 32'(W_Retired), 32'd12);
    Stall = 1'b0; M_Valid = 1'b0;
    tick();
    chk("inval_valid", 32'(W_Valid), 32'd0);
    chk("inval_ret", 32'(W_Retired), 32'd12);

    // 6: retire counter wrap (4-bit)
    drive(1'b1, 32'h0000_3030, 3'd0, 2'd0, 32'h0000_0010, 32'h0, 1'b1, 5'd3);
    for (int i = 0; i < 3; i++) tick();
    chk("ret_max", 32'(W_Retired), 32'd15);
    tick();
    chk("ret_wrap", 32'(W_Retired), 32'd0);
    chk("ret_wrap_valid", 32'(W_Valid), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
